// File: rtl/punc_program_loader.sv
// punc_program_loader: boot-time byte-stream loader that fills PUnC memory; optional LOADER_CHECKSUM_EN adds a frame checksum
module punc_program_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [15:0]       mem_w_data,
    output logic              mem_w_en,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_written
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR
    } state_t;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, cnt_q, cnt_d, words_q, words_d, waddr_q, waddr_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              acc;
    logic [ADDR_W:0]   waddr_full;
    logic [ADDR_W-1:0] cnt_n, words_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif
    assign busy          = !(state_q inside {IDLE, DONE, ERROR});
    assign in_ready      = busy;
    assign done          = state_q == DONE;
    assign error         = state_q == ERROR;
    assign cpu_hold      = busy | error;
    assign mem_w_en      = wen_q;
    assign mem_w_addr    = waddr_q;
    assign mem_w_data    = wdata_q;
    assign words_written = words_q;
    assign acc           = in_valid && in_ready;
    assign waddr_full    = {1'b0, base_q} + {1'b0, words_q};
    assign cnt_n         = {cnt_q[ADDR_W-9:0], in_data};
    assign words_n       = words_q + ADDR_W'(1);
    // next-state: frame parsing, bounds checks and write staging
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = acc ? sum_q + in_data : sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d = ADDR_HI;
                words_d = '0;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
            ADDR_HI: if (acc) begin
                base_d  = {base_q[ADDR_W-9:0], in_data};
                state_d = ADDR_LO;
            end
            ADDR_LO: if (acc) begin
                base_d  = {base_q[ADDR_W-9:0], in_data};
                state_d = CNT_HI;
            end
            CNT_HI: if (acc) begin
                cnt_d   = cnt_n;
                state_d = CNT_LO;
            end
            CNT_LO: if (acc) begin
                cnt_d   = cnt_n;
                state_d = cnt_n == '0 ? FIN : ({1'b0, base_q} >= DEPTH ? ERROR : DATA_HI);
            end
            DATA_HI: if (acc) begin
                hi_d    = in_data;
                state_d = DATA_LO;
            end
            DATA_LO: if (acc) begin
                if (waddr_full >= DEPTH) state_d = ERROR;
                else begin
                    wen_d   = 1'b1;
                    waddr_d = waddr_full[ADDR_W-1:0];
                    wdata_d = {hi_q, in_data};
                    words_d = words_n;
                    state_d = words_n == cnt_q ? FIN : DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (acc) state_d = 8'(sum_q + in_data) == 8'h00 ? DONE : ERROR;
`endif
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers; reset drops any staged write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            words_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_punc_program_loader.sv
// tb_punc_program_loader: directed self-checking bench for punc_program_loader
module tb_punc_program_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_w_en, cpu_hold, busy, done, error;
    logic [15:0] mem_w_addr, mem_w_data, words_written;
    int          errors = 0, checks = 0, wr_cnt = 0, n0, fl;
    logic [15:0] wa [64];
    logic [15:0] wd [64];
    logic [7:0]  fr [16];

    punc_program_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_w_en(mem_w_en), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_w_en === 1'b1 && wr_cnt < 64) begin
        wa[wr_cnt] = mem_w_addr;
        wd[wr_cnt] = mem_w_data;
        wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] csum(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + fr[i];
        return 8'h00 - s;
    endfunction

    task automatic mk_frame1(input logic [7:0] corrupt);
        fr[0] = 8'h00; fr[1] = 8'h10; fr[2] = 8'h00; fr[3] = 8'h02;
        fr[4] = 8'h12; fr[5] = 8'h34; fr[6] = 8'hAB; fr[7] = 8'hCD;
        fl = 8;
`ifdef LOADER_CHECKSUM_EN
        fr[8] = csum(8) + corrupt;
        fl = 9;
`else
        if (corrupt != 8'h00) fl = 8;
`endif
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input int first, input int last, input int gapped);
        for (int i = first; i < last; i++) begin
            int n = 0;
            if (gapped != 0) repeat ((i % 2) ? 3 : 1) @(negedge clk);
            in_valid = 1'b1;
            in_data  = fr[i];
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_wen"},   32'(mem_w_en), 0);
        chk({tag, "_addr"},  32'(mem_w_addr), 0);
        chk({tag, "_data"},  32'(mem_w_data), 0);
        chk({tag, "_hold"},  32'(cpu_hold), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_err"},   32'(error), 0);
        chk({tag, "_words"}, 32'(words_written), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;
        // basic frame, back-to-back bytes
        mk_frame1(8'h00);
        start_pulse();
        n0 = wr_cnt;
        send_frame(0, 7, 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_hold", 32'(cpu_hold), 1);
        chk("t1_first_wr", 32'(wr_cnt - n0), 1);
        send_frame(7, 8, 0);
        chk("t1_wen", 32'(mem_w_en), 1);
        chk("t1_waddr", 32'(mem_w_addr), 'h11);
        chk("t1_wdata", 32'(mem_w_data), 'hABCD);
        chk("t1_words_lat", 32'(words_written), 2);
        send_frame(8, fl, 0);
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(error), 0);
        chk("t1_hold_end", 32'(cpu_hold), 0);
        chk("t1_words", 32'(words_written), 2);
        chk("t1_nwr", 32'(wr_cnt - n0), 2);
        chk("t1_a0", 32'(wa[n0]), 'h10);
        chk("t1_d0", 32'(wd[n0]), 'h1234);
        chk("t1_a1", 32'(wa[n0+1]), 'h11);
        chk("t1_d1", 32'(wd[n0+1]), 'hABCD);
        // gapped stream with a start pulse that must be ignored mid-frame
        start_pulse();
        chk("t2_clr_done", 32'(done), 0);
        chk("t2_clr_words", 32'(words_written), 0);
        n0 = wr_cnt;
        send_frame(0, 3, 1);
        start_pulse();
        send_frame(3, fl, 1);
        repeat (2) @(negedge clk);
        chk("t2_done", 32'(done), 1);
        chk("t2_nwr", 32'(wr_cnt - n0), 2);
        chk("t2_a0", 32'(wa[n0]), 'h10);
        chk("t2_d0", 32'(wd[n0]), 'h1234);
        chk("t2_a1", 32'(wa[n0+1]), 'h11);
        chk("t2_d1", 32'(wd[n0+1]), 'hABCD);
        chk("t2_words", 32'(words_written), 2);
        // second word runs past the end of memory
        fr[0] = 8'h03; fr[1] = 8'hFF; fr[2] = 8'h00; fr[3] = 8'h02;
        fr[4] = 8'h11; fr[5] = 8'h11; fr[6] = 8'h22; fr[7] = 8'h22;
        start_pulse();
        n0 = wr_cnt;
        send_frame(0, 8, 0);
        @(negedge clk);
        chk("t3_err", 32'(error), 1);
        chk("t3_done", 32'(done), 0);
        chk("t3_hold", 32'(cpu_hold), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_ready", 32'(in_ready), 0);
        chk("t3_words", 32'(words_written), 1);
        chk("t3_nwr", 32'(wr_cnt - n0), 1);
        chk("t3_a0", 32'(wa[n0]), 'h3FF);
        chk("t3_d0", 32'(wd[n0]), 'h1111);
        // empty frame
        fr[0] = 8'h00; fr[1] = 8'h20; fr[2] = 8'h00; fr[3] = 8'h00;
        fl = 4;
`ifdef LOADER_CHECKSUM_EN
        fr[4] = csum(4);
        fl = 5;
`endif
        start_pulse();
        chk("t4_clr_err", 32'(error), 0);
        n0 = wr_cnt;
        send_frame(0, fl, 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_err", 32'(error), 0);
        chk("t4_words", 32'(words_written), 0);
        chk("t4_hold", 32'(cpu_hold), 0);
        @(negedge clk);
        chk("t4_nwr", 32'(wr_cnt - n0), 0);
`ifdef LOADER_CHECKSUM_EN
        // corrupted checksum keeps written words but flags error
        mk_frame1(8'h01);
        start_pulse();
        n0 = wr_cnt;
        send_frame(0, fl, 0);
        @(negedge clk);
        chk("t5_err", 32'(error), 1);
        chk("t5_done", 32'(done), 0);
        chk("t5_nwr", 32'(wr_cnt - n0), 2);
`endif
        // reset in the middle of a frame, then reload
        mk_frame1(8'h00);
        start_pulse();
        n0 = wr_cnt;
        send_frame(0, 5, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("t6");
        chk("t6_nwr", 32'(wr_cnt - n0), 0);
        rst = 1'b0;
        start_pulse();
        n0 = wr_cnt;
        send_frame(0, fl, 0);
        @(negedge clk);
        chk("t6_done", 32'(done), 1);
        chk("t6_nwr2", 32'(wr_cnt - n0), 2);
        chk("t6_a0", 32'(wa[n0]), 'h10);
        chk("t6_d1", 32'(wd[n0+1]), 'hABCD);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
